tft_8080_panel_model: RTL and testbench
=======================================

Name: tft_8080_panel_model

Overview:
Parametrised behavioural and synthesizable model of an 8080-style parallel TFT panel. It is used as the device-side partner in cocotb benches for the PMOD/parallel TFT controllers. It decodes command/data writes, answers register reads, generates a programmable tearing-effect (TE) pulse, and pushes every captured bus write into a FIFO for the bench to drain. It generalises the fixed 8-bit responder to configurable bus width, TE timing, panel ID and capture depth, and adds panel power/TE state.

Parameters:
DATA_WIDTH, 8, panel bus width; legal values are 8 or 16; commands use bits [7:0].
TE_PERIOD, 100, TE period in clk cycles; must be at least 2.
TE_WIDTH, 1, TE high time in clk cycles; must be at least 1 and less than TE_PERIOD.
PANEL_ID, 24'h9341AA, 3-byte ID returned by command 0x04.
READ_DEFAULT, 8'hAA, value returned for unrecognised read commands.
FIFO_DEPTH_LOG2, 4, capture FIFO depth is 2**FIFO_DEPTH_LOG2.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_reset_n  in  1  panel hard reset, active low
i_cs_n  in  1  chip select, active low
i_dc  in  1  register/data select; 0 = command, 1 = data
i_wr_n  in  1  write strobe, active low
i_rd_n  in  1  read strobe, active low
i_data  in  DATA_WIDTH  bus value driven by the controller
o_data  out  DATA_WIDTH  bus value driven by the panel
o_data_oe  out  1  panel drives the bus
o_tearing_effect  out  1  TE output
o_cap_valid  out  1  capture FIFO not empty
i_cap_ready  in  1  pop capture FIFO
o_cap_data  out  DATA_WIDTH  head entry data
o_cap_is_cmd  out  1  head entry is a command write
o_cap_overflow  out  1  sticky flag; a write was dropped because the FIFO was full
o_last_cmd  out  8  most recent command byte
o_pixel_count  out  32  data writes received after a 0x2C command
o_sleep_out  out  1  panel power state
o_display_on  out  1  panel power state

Behaviour:
- Reset (rst): all outputs are 0, FIFO is empty, and the TE counter is 0.
- Panel hard reset (i_reset_n=0, sampled each clk): clears o_last_cmd, param/read indices, o_pixel_count, o_sleep_out, o_display_on and te_en. The FIFO and o_cap_overflow are preserved.
- Strobe detection: i_wr_n and i_rd_n are registered. A write commits on the clk where the registered value is 0, the current value is 1, and i_cs_n=0. Data and i_dc are taken from the previous cycle's registered copies.
- Command write (dc=0):
  - o_last_cmd <= data[7:0]; the param index and read index clear.
  - 0x11 sets sleep_out; 0x10 clears it.
  - 0x29 sets display_on; 0x28 clears it.
  - 0x35 sets te_en; 0x34 clears it.
  - 0x2C clears o_pixel_count.
  - 0x01 (SW reset) behaves like a panel hard reset, except o_last_cmd = 0x01.
- Data write (dc=1): the param index increments and saturates at 255. If o_last_cmd==0x2C, o_pixel_count increments and wraps at 2**32.
- Every committed write pushes {dc==0, data} into the FIFO.
  - Full FIFO: the entry is dropped and o_cap_overflow is set.
  - Push and pop on the same clk while full: the push succeeds.
  - FIFO output is first-word fall-through; a pop when empty is ignored.
- Read path:
  - o_data_oe <= !i_cs_n & !i_rd_n, registered, so it has 1 cycle of latency.
  - o_data is loaded at the cycle o_data_oe rises and holds while it is high. It is zero-extended to DATA_WIDTH.
  - The read index increments on the rd_n rising edge (with cs_n low).
  - Response by o_last_cmd:
    - 0x00 returns 0x01.
    - 0x04: index0 returns 0x00 (dummy), index1-3 return PANEL_ID bytes MSB first, later indices return 0x00.
    - 0x0A returns {1'b1, 2'b00, sleep_out, 1'b1, display_on, 2'b00}.
    - 0x0E returns {te_en & o_tearing_effect, 7'b0}.
    - 0x2C returns 0xFF.
    - 0xB8 returns 0xAA.
    - Any other command returns READ_DEFAULT.
  - When o_data_oe=0, o_data = 0.
- TE generator:
  - The counter runs 0..TE_PERIOD-1, wraps, and runs regardless of te_en.
  - o_tearing_effect = te_en & (count < TE_WIDTH), registered.
  - Enabling TE mid-period takes effect at the next qualifying count; there is no partial restart.
- Simultaneous wr and rd strobes: the write commits and the read is still served.

Optional Feature:
TFT_MODEL_PROTOCOL_CHECK_EN:
- When defined, adds output o_protocol_error (1 bit, sticky, cleared only by rst). It sets on any of:
  - i_wr_n and i_rd_n both low while cs_n=0;
  - i_cs_n rising while i_wr_n or i_rd_n is low;
  - a data write with no command since reset.
- When undefined, the port and logic are absent, and the model silently accepts such sequences.

Test Plan:
- Write cmd 0x11 then cmd 0x29; read cmd 0x0A -> o_data=0x9C; FIFO holds {1,0x11},{1,0x29}.
- Cmd 0x04, four reads -> 0x00, 0x93, 0x41, 0xAA; a fifth read -> 0x00.
- Cmd 0x35, TE_PERIOD=100, TE_WIDTH=3 -> TE high 3 of every 100 cycles; cmd 0x34 -> TE stays 0; cmd 0x0E read during high -> 0x80.
- Cmd 0x2C, 20 data writes with FIFO_DEPTH_LOG2=4 and no pops -> o_pixel_count=20, 16 entries captured, o_cap_overflow=1; drain returns {1,0x2C} then data in order.
- DATA_WIDTH=16: data write 0xBEEF -> o_cap_data=0xBEEF, is_cmd=0; read cmd 0xB8 -> 0x00AA.
- i_reset_n pulse after cmd 0x11/0x35 -> sleep_out=0, TE stays low; FIFO contents unchanged; rst mid-write -> all outputs 0.

Source files
------------

// File: rtl/tft_8080_panel_model_if.sv
// 8080-style parallel panel bus: controller side is the master, panel model is the slave.
interface tft_8080_panel_model_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_reset_n;
    logic                  i_cs_n;
    logic                  i_dc;
    logic                  i_wr_n;
    logic                  i_rd_n;
    logic [DATA_WIDTH-1:0] i_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_oe;

    modport master (
        output i_reset_n, i_cs_n, i_dc, i_wr_n, i_rd_n, i_data,
        input  o_data, o_data_oe
    );

    modport slave (
        input  i_reset_n, i_cs_n, i_dc, i_wr_n, i_rd_n, i_data,
        output o_data, o_data_oe
    );
endinterface

// File: rtl/tft_8080_panel_model.sv
// 8080 TFT panel model: command/data decode, register reads, TE pulse and a capture FIFO.
// Optional TFT_MODEL_PROTOCOL_CHECK_EN adds a sticky o_protocol_error output.
module tft_8080_panel_model #(
    parameter int          DATA_WIDTH      = 8,
    parameter int          TE_PERIOD       = 100,
    parameter int          TE_WIDTH        = 1,
    parameter logic [23:0] PANEL_ID        = 24'h9341AA,
    parameter logic [7:0]  READ_DEFAULT    = 8'hAA,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tft_8080_panel_model_if.slave bus,
    output logic                  o_tearing_effect,
    output logic                  o_cap_valid,
    input  logic                  i_cap_ready,
    output logic [DATA_WIDTH-1:0] o_cap_data,
    output logic                  o_cap_is_cmd,
    output logic                  o_cap_overflow,
    output logic [7:0]            o_last_cmd,
    output logic [31:0]           o_pixel_count,
    output logic                  o_sleep_out,
    output logic                  o_display_on
`ifdef TFT_MODEL_PROTOCOL_CHECK_EN
    ,
    output logic                  o_protocol_error
`endif
);
    localparam int TE_CW      = (TE_PERIOD > 2) ? $clog2(TE_PERIOD) : 1;
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [TE_CW-1:0] TE_LAST = TE_CW'(TE_PERIOD - 1);
    localparam logic [TE_CW-1:0] TE_HIGH = TE_CW'(TE_WIDTH);

    logic                   r_wr_n_q, r_rd_n_q, r_dc_q;
    logic [DATA_WIDTH-1:0]  r_data_q;
    logic [7:0]             r_last_cmd, r_rd_idx;
    logic [31:0]            r_pixel_count;
    logic                   r_sleep_out, r_display_on, r_te_en, r_te;
    logic [TE_CW-1:0]       r_te_cnt;
    logic                   r_data_oe;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [DATA_WIDTH:0]    r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
    logic                   r_overflow;

    logic       w_wr_commit, w_rd_rise, w_oe_next;
    logic       w_fifo_empty, w_fifo_full, w_push, w_pop;
    logic [7:0] w_cmd, w_resp;

    // A strobe commits on its rising edge; bus value and dc come from the cycle before.
    assign w_wr_commit = !r_wr_n_q && bus.i_wr_n && !bus.i_cs_n;
    assign w_rd_rise   = !r_rd_n_q && bus.i_rd_n && !bus.i_cs_n;
    assign w_oe_next   = !bus.i_cs_n && !bus.i_rd_n;
    assign w_cmd       = r_data_q[7:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_n_q      <= 1'b1;
            r_rd_n_q      <= 1'b1;
            r_dc_q        <= 1'b0;
            r_data_q      <= '0;
            r_last_cmd    <= 8'h00;
            r_rd_idx      <= 8'h00;
            r_pixel_count <= 32'd0;
            r_sleep_out   <= 1'b0;
            r_display_on  <= 1'b0;
            r_te_en       <= 1'b0;
        end else begin
            r_wr_n_q <= bus.i_wr_n;
            r_rd_n_q <= bus.i_rd_n;
            r_dc_q   <= bus.i_dc;
            r_data_q <= bus.i_data;
            if (!bus.i_reset_n) begin
                r_last_cmd    <= 8'h00;
                r_rd_idx      <= 8'h00;
                r_pixel_count <= 32'd0;
                r_sleep_out   <= 1'b0;
                r_display_on  <= 1'b0;
                r_te_en       <= 1'b0;
            end else if (w_wr_commit && !r_dc_q) begin
                r_last_cmd <= w_cmd;
                r_rd_idx   <= 8'h00;
                case (w_cmd)
                    8'h01: begin
                        r_pixel_count <= 32'd0;
                        r_sleep_out   <= 1'b0;
                        r_display_on  <= 1'b0;
                        r_te_en       <= 1'b0;
                    end
                    8'h10: r_sleep_out   <= 1'b0;
                    8'h11: r_sleep_out   <= 1'b1;
                    8'h28: r_display_on  <= 1'b0;
                    8'h29: r_display_on  <= 1'b1;
                    8'h34: r_te_en       <= 1'b0;
                    8'h35: r_te_en       <= 1'b1;
                    8'h2C: r_pixel_count <= 32'd0;
                    default: ;
                endcase
            end else begin
                if (w_wr_commit && r_last_cmd == 8'h2C)
                    r_pixel_count <= r_pixel_count + 32'd1;
                if (w_rd_rise && r_rd_idx != 8'hFF)
                    r_rd_idx <= r_rd_idx + 8'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_resp = READ_DEFAULT;
        case (r_last_cmd)
            8'h00: w_resp = 8'h01;
            8'h04: begin
                case (r_rd_idx)
                    8'd1:    w_resp = PANEL_ID[23:16];
                    8'd2:    w_resp = PANEL_ID[15:8];
                    8'd3:    w_resp = PANEL_ID[7:0];
                    default: w_resp = 8'h00;
                endcase
            end
            8'h0A: w_resp = {1'b1, 2'b00, r_sleep_out, 1'b1, r_display_on, 2'b00};
            8'h0E: w_resp = {r_te_en & r_te, 7'b0};
            8'h2C: w_resp = 8'hFF;
            8'hB8: w_resp = 8'hAA;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_oe <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_data_oe <= w_oe_next;
            if (!w_oe_next)
                r_rdata <= '0;
            else if (!r_data_oe)
                r_rdata <= DATA_WIDTH'(w_resp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_te_cnt <= '0;
            r_te     <= 1'b0;
        end else begin
            r_te_cnt <= (r_te_cnt == TE_LAST) ? '0 : r_te_cnt + 1'b1;
            r_te     <= r_te_en && (r_te_cnt < TE_HIGH);
        end
    end

    // Pop is evaluated first so a push into a full FIFO succeeds when the head leaves.
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}});
    assign w_pop        = i_cap_ready && !w_fifo_empty;
    assign w_push       = w_wr_commit && (!w_fifo_full || w_pop);

    // NOTE: the capture memory has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {!r_dc_q, r_data_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_commit && w_fifo_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

`ifdef TFT_MODEL_PROTOCOL_CHECK_EN
    logic r_cs_n_q, r_seen_cmd, r_protocol_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n_q         <= 1'b1;
            r_seen_cmd       <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            r_cs_n_q <= bus.i_cs_n;
            if (w_wr_commit && !r_dc_q)
                r_seen_cmd <= 1'b1;
            if ((!bus.i_wr_n && !bus.i_rd_n && !bus.i_cs_n) ||
                (!r_cs_n_q && bus.i_cs_n && (!bus.i_wr_n || !bus.i_rd_n)) ||
                (w_wr_commit && r_dc_q && !r_seen_cmd))
                r_protocol_error <= 1'b1;
        end
    end

    assign o_protocol_error = r_protocol_error;
`endif

    assign bus.o_data       = r_rdata;
    assign bus.o_data_oe    = r_data_oe;
    assign o_tearing_effect = r_te;
    assign o_cap_valid      = !w_fifo_empty;
    assign {o_cap_is_cmd, o_cap_data} = w_fifo_empty ? '0 : r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    assign o_cap_overflow   = r_overflow;
    assign o_last_cmd       = r_last_cmd;
    assign o_pixel_count    = r_pixel_count;
    assign o_sleep_out      = r_sleep_out;
    assign o_display_on     = r_display_on;

endmodule

// File: tb/tb_tft_8080_panel_model.sv
// Self-checking bench for tft_8080_panel_model: directed scenarios plus randomized bus traffic
// compared every cycle against a behavioural panel model.
module tb_tft_8080_panel_model;
    localparam int          DW        = 16;
    localparam int          TE_PERIOD = 100;
    localparam int          TE_WIDTH  = 3;
    localparam int          FIFO_L    = 4;
    localparam int          FDEPTH    = 1 << FIFO_L;
    localparam logic [23:0] PANEL_ID  = 24'h9341AA;
    localparam logic [7:0]  READ_DEF  = 8'hAA;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cap_ready = 1'b0;
    logic          te, cap_valid, cap_is_cmd, cap_ovf, sleep_out, display_on;
    logic [DW-1:0] cap_data;
    logic [7:0]    last_cmd;
    logic [31:0]   pix;
`ifdef TFT_MODEL_PROTOCOL_CHECK_EN
    logic          proto_err;
`endif

    tft_8080_panel_model_if #(.DATA_WIDTH(DW)) bus ();

    tft_8080_panel_model #(
        .DATA_WIDTH(DW), .TE_PERIOD(TE_PERIOD), .TE_WIDTH(TE_WIDTH),
        .PANEL_ID(PANEL_ID), .READ_DEFAULT(READ_DEF), .FIFO_DEPTH_LOG2(FIFO_L)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .o_tearing_effect(te), .o_cap_valid(cap_valid), .i_cap_ready(cap_ready),
        .o_cap_data(cap_data), .o_cap_is_cmd(cap_is_cmd), .o_cap_overflow(cap_ovf),
        .o_last_cmd(last_cmd), .o_pixel_count(pix),
        .o_sleep_out(sleep_out), .o_display_on(display_on)
`ifdef TFT_MODEL_PROTOCOL_CHECK_EN
        , .o_protocol_error(proto_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_ready = 1'b0;
    logic [DW:0] drained[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural panel model ----------------
    logic [7:0]    m_last_cmd, m_rd_idx;
    logic [31:0]   m_pix;
    logic          m_sleep, m_disp, m_te_en, m_te, m_oe, m_ovf;
    logic [DW-1:0] m_rdata;
    int            m_tcount;
    logic [DW:0]   m_q[$];
    logic          m_wr_q, m_rd_q, m_dc_q;
    logic [DW-1:0] m_data_q;
    bit            m_started = 1'b0;

    function automatic logic [7:0] model_resp();
        case (m_last_cmd)
            8'h00: return 8'h01;
            8'h04: return (m_rd_idx >= 1 && m_rd_idx <= 3) ? 8'(PANEL_ID >> (8 * (3 - int'(m_rd_idx)))) : 8'h00;
            8'h0A: return {1'b1, 2'b00, m_sleep, 1'b1, m_disp, 2'b00};
            8'h0E: return {m_te_en & m_te, 7'b0};
            8'h2C: return 8'hFF;
            8'hB8: return 8'hAA;
            default: return READ_DEF;
        endcase
    endfunction

    task automatic model_panel_reset(input logic [7:0] cmd);
        m_last_cmd = cmd; m_rd_idx = 0; m_pix = 0;
        m_sleep = 0; m_disp = 0; m_te_en = 0;
    endtask

    // Inputs are stable from posedge+1 until the next posedge, so at negedge they are the
    // values the upcoming edge will sample.
    task automatic model_step();
        bit commit, rd_rise, oe_next;
        if (rst) begin
            model_panel_reset(8'h00);
            m_te = 0; m_oe = 0; m_ovf = 0; m_rdata = '0; m_tcount = 0;
            m_q.delete();
            m_wr_q = 1; m_rd_q = 1; m_dc_q = 0; m_data_q = '0;
            m_started = 1'b1;
            return;
        end
        commit  = !m_wr_q && bus.i_wr_n && !bus.i_cs_n;
        rd_rise = !m_rd_q && bus.i_rd_n && !bus.i_cs_n;
        oe_next = !bus.i_cs_n && !bus.i_rd_n;
        if (!oe_next) m_rdata = '0;
        else if (!m_oe) m_rdata = DW'(model_resp());
        m_oe = oe_next;
        if (cap_ready && m_q.size() != 0) void'(m_q.pop_front());
        if (commit) begin
            if (m_q.size() < FDEPTH) m_q.push_back({!m_dc_q, m_data_q});
            else m_ovf = 1;
        end
        m_te = m_te_en && ((m_tcount % TE_PERIOD) < TE_WIDTH);
        m_tcount++;
        if (!bus.i_reset_n) model_panel_reset(8'h00);
        else if (commit && !m_dc_q) begin
            m_last_cmd = m_data_q[7:0];
            m_rd_idx = 0;
            case (m_data_q[7:0])
                8'h01: model_panel_reset(8'h01);
                8'h10: m_sleep = 0;
                8'h11: m_sleep = 1;
                8'h28: m_disp = 0;
                8'h29: m_disp = 1;
                8'h34: m_te_en = 0;
                8'h35: m_te_en = 1;
                8'h2C: m_pix = 0;
                default: ;
            endcase
        end else begin
            if (commit && m_last_cmd == 8'h2C) m_pix++;
            if (rd_rise && m_rd_idx != 8'hFF) m_rd_idx++;
        end
        m_wr_q = bus.i_wr_n; m_rd_q = bus.i_rd_n; m_dc_q = bus.i_dc; m_data_q = bus.i_data;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("o_data", bus.o_data, m_rdata);
                check("o_data_oe", bus.o_data_oe, m_oe);
                check("te", te, m_te);
                check("cap_valid", cap_valid, m_q.size() != 0);
                check("cap_head", {cap_is_cmd, cap_data}, (m_q.size() != 0) ? m_q[0] : '0);
                check("cap_overflow", cap_ovf, m_ovf);
                check("last_cmd", last_cmd, m_last_cmd);
                check("pixel_count", pix, m_pix);
                check("sleep_out", sleep_out, m_sleep);
                check("display_on", display_on, m_disp);
            end
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) cap_ready = ($urandom_range(0, 2) == 0);
    endtask

    task automatic bus_write(input logic dc, input logic [DW-1:0] d);
        bus.i_cs_n = 0; bus.i_dc = dc; bus.i_data = d; bus.i_wr_n = 0;
        tick();
        bus.i_wr_n = 1;
        tick();
        bus.i_cs_n = 1;
    endtask

    task automatic bus_read(output logic [DW-1:0] v);
        bus.i_cs_n = 0; bus.i_rd_n = 0;
        tick();
        v = bus.o_data;
        bus.i_rd_n = 1;
        tick();
        bus.i_cs_n = 1;
    endtask

    task automatic bus_write_read(input logic dc, input logic [DW-1:0] d);
        bus.i_cs_n = 0; bus.i_dc = dc; bus.i_data = d; bus.i_wr_n = 0; bus.i_rd_n = 0;
        tick();
        bus.i_wr_n = 1; bus.i_rd_n = 1;
        tick();
        bus.i_cs_n = 1;
    endtask

    task automatic pop_one();
        cap_ready = 1;
        tick();
        cap_ready = 0;
    endtask

    task automatic drain_all(output int n);
        n = 0;
        drained.delete();
        for (int i = 0; i < 64 && cap_valid; i++) begin
            drained.push_back({cap_is_cmd, cap_data});
            pop_one();
            n++;
        end
    endtask

    task automatic count_te(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (te) highs++;
        end
    endtask

    logic [7:0]    cmds [14] = '{8'h00, 8'h04, 8'h0A, 8'h0E, 8'h2C, 8'hB8, 8'h11,
                                 8'h10, 8'h29, 8'h28, 8'h35, 8'h34, 8'h01, 8'h55};
    logic [DW-1:0] v;
    int            n, highs;
    logic [15:0]   exp_id [5] = '{16'h0000, 16'h0093, 16'h0041, 16'h00AA, 16'h0000};

    initial begin
        bus.i_reset_n = 1; bus.i_cs_n = 1; bus.i_dc = 0;
        bus.i_wr_n = 1; bus.i_rd_n = 1; bus.i_data = '0;
        repeat (3) tick();
        check("rst_te", te, 0);
        check("rst_cap_valid", cap_valid, 0);
        check("rst_last_cmd", last_cmd, 0);
        check("rst_data_oe", bus.o_data_oe, 0);
        rst = 0;
        tick();

        // Status read after sleep-out and display-on.
        bus_write(0, 16'h0011);
        bus_write(0, 16'h0029);
        bus_write(0, 16'h000A);
        bus_read(v);
        check("read_0A", v, 16'h009C);
        check("fifo_head_11", {cap_is_cmd, cap_data}, {1'b1, 16'h0011});
        pop_one();
        check("fifo_head_29", {cap_is_cmd, cap_data}, {1'b1, 16'h0029});
        pop_one();
        pop_one();
        check("fifo_empty", cap_valid, 0);

        // ID read sequence.
        bus_write(0, 16'h0004);
        for (int i = 0; i < 5; i++) begin
            bus_read(v);
            check($sformatf("read_id%0d", i), v, exp_id[i]);
        end

        // Tearing effect on, read during high, then off.
        bus_write(0, 16'h0035);
        bus_write(0, 16'h000E);
        for (int i = 0; i < 250 && te; i++) tick();
        for (int i = 0; i < 250 && !te; i++) tick();
        check("te_rise_seen", te, 1);
        bus_read(v);
        check("read_0E_high", v, 16'h0080);
        count_te(100, highs);
        check("te_high_per_period", highs, 3);
        bus_write(0, 16'h0034);
        count_te(150, highs);
        check("te_off_highs", highs, 0);

        // Pixel stream overflowing the capture FIFO.
        drain_all(n);
        check("ovf_before", cap_ovf, 0);
        bus_write(0, 16'h002C);
        for (int i = 0; i < 20; i++) bus_write(1, 16'h0100 + 16'(i));
        check("pixel_count_20", pix, 20);
        check("ovf_after", cap_ovf, 1);
        drain_all(n);
        check("drain_count", n, 16);
        check("drain_first", drained[0], {1'b1, 16'h002C});
        for (int k = 1; k < 16 && k < n; k++)
            check($sformatf("drain_%0d", k), drained[k], {1'b0, 16'h0100 + 16'(k - 1)});

        // Full-width data and zero-extended read.
        bus_write(1, 16'hBEEF);
        check("cap_beef", {cap_is_cmd, cap_data}, {1'b0, 16'hBEEF});
        check("pixel_count_21", pix, 21);
        bus_write(0, 16'h00B8);
        bus_read(v);
        check("read_B8", v, 16'h00AA);

        // Panel hard reset keeps the FIFO.
        drain_all(n);
        bus_write(0, 16'h0011);
        bus_write(0, 16'h0035);
        check("sleep_before", sleep_out, 1);
        bus.i_reset_n = 0;
        tick();
        bus.i_reset_n = 1;
        check("sleep_after_hw_reset", sleep_out, 0);
        check("last_cmd_after_hw_reset", last_cmd, 0);
        check("fifo_kept_head", {cap_is_cmd, cap_data}, {1'b1, 16'h0011});
        count_te(150, highs);
        check("te_after_hw_reset", highs, 0);
        drain_all(n);
        check("fifo_kept_count", n, 2);

        // System reset in the middle of a write.
        bus_write(0, 16'h0029);
        bus.i_cs_n = 0; bus.i_dc = 0; bus.i_data = 16'h0011; bus.i_wr_n = 0;
        tick();
        rst = 1;
        bus.i_wr_n = 1;
        tick();
        tick();
        check("midrst_display", display_on, 0);
        check("midrst_last_cmd", last_cmd, 0);
        check("midrst_ovf", cap_ovf, 0);
        check("midrst_valid", cap_valid, 0);
        bus.i_cs_n = 1;
        rst = 0;
        tick();

        // Randomized traffic against the model.
        rand_ready = 1;
        for (int op = 0; op < 1500; op++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: bus_write(0, DW'(cmds[$urandom_range(0, 13)]));
                3, 4:    bus_write(1, DW'($urandom()));
                5, 6:    bus_read(v);
                7:       bus_write_read($urandom_range(0, 1) == 1, DW'($urandom()));
                8:       repeat ($urandom_range(1, 4)) tick();
                default: begin
                    if ($urandom_range(0, 7) == 0) begin
                        bus.i_reset_n = 0;
                        tick();
                        bus.i_reset_n = 1;
                    end else begin
                        tick();
                    end
                end
            endcase
        end
        rand_ready = 0;
        cap_ready = 0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
